pc_fetch_ctrl: RTL and testbench



---
 rtl/pc_fetch_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program-counter controller: boots from a memory-held vector, steps, redirects, stalls.
// Interrupt entry/return with saved epc is built only when PC_IRQ_EN is defined.
module pc_fetch_ctrl #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned RST_VEC_ADDR = 0,
    parameter int unsigned IRQ_VEC_ADDR = 1,
    parameter int unsigned PC_STEP      = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              StallF,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              irq_req,
    input  logic              ret_en,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [ADDR_W-1:0] vec_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic              in_isr,
    output logic              irq_ack
);

    localparam logic [2:0] ST_BOOT_RD = 3'd0;
    localparam logic [2:0] ST_BOOT_LD = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;

    localparam logic [ADDR_W-1:0] L_RST_VEC = RST_VEC_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] L_PC_STEP = PC_STEP[ADDR_W-1:0];

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              r_valid;
    logic              w_valid_nxt;

    assign w_pc_inc = r_pc + L_PC_STEP;
    assign pc_out   = r_pc;
    assign pc_valid = r_valid;

`ifdef PC_IRQ_EN
    localparam logic [2:0] ST_IRQ_RD = 3'd3;
    localparam logic [2:0] ST_IRQ_LD = 3'd4;
    localparam logic [ADDR_W-1:0] L_IRQ_VEC = IRQ_VEC_ADDR[ADDR_W-1:0];

    logic [ADDR_W-1:0] r_epc;
    logic [ADDR_W-1:0] w_epc_nxt;
    logic              r_in_isr;
    logic              w_in_isr_nxt;
    logic              r_irq_ack;
    logic [ADDR_W-1:0] r_vec_addr;
    logic              w_irq_fetch_nxt;

    assign w_irq_fetch_nxt = (w_state_nxt == ST_IRQ_RD) || (w_state_nxt == ST_IRQ_LD);
    assign vec_addr        = r_vec_addr;
    assign in_isr          = r_in_isr;
    assign irq_ack         = r_irq_ack;

    // Next-state and datapath decode with interrupt support.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_valid_nxt  = r_valid;
        w_epc_nxt    = r_epc;
        w_in_isr_nxt = r_in_isr;
        case (r_state)
            ST_BOOT_RD: begin
                w_state_nxt = ST_BOOT_LD;
            end
            ST_BOOT_LD: begin
                w_pc_nxt    = vec_data;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_en) begin
                    w_pc_nxt = redirect_pc;
                end else if (ret_en && r_in_isr) begin
                    w_pc_nxt     = r_epc;
                    w_in_isr_nxt = 1'b0;
                end else if (irq_req && !r_in_isr && !StallF) begin
                    w_epc_nxt   = w_pc_inc;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IRQ_RD;
                end else if (StallF) begin
                    w_pc_nxt = r_pc;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            ST_IRQ_RD: begin
                // A branch resolved during entry becomes the handler's return target.
                if (redirect_en) begin
                    w_epc_nxt = redirect_pc;
                end else begin
                    w_epc_nxt = r_epc;
                end
                w_state_nxt = ST_IRQ_LD;
            end
            ST_IRQ_LD: begin
                if (redirect_en) begin
                    w_epc_nxt = redirect_pc;
                end else begin
                    w_epc_nxt = r_epc;
                end
                w_pc_nxt     = vec_data;
                w_valid_nxt  = 1'b1;
                w_in_isr_nxt = 1'b1;
                w_state_nxt  = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_BOOT_RD;
                w_pc_nxt    = {ADDR_W{1'b0}};
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, PC and interrupt registers; vec_addr/irq_ack are registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_BOOT_RD;
            r_pc       <= {ADDR_W{1'b0}};
            r_valid    <= 1'b0;
            r_epc      <= {ADDR_W{1'b0}};
            r_in_isr   <= 1'b0;
            r_irq_ack  <= 1'b0;
            r_vec_addr <= L_RST_VEC;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_epc      <= w_epc_nxt;
            r_in_isr   <= w_in_isr_nxt;
            r_irq_ack  <= (w_state_nxt == ST_IRQ_LD);
            r_vec_addr <= w_irq_fetch_nxt ? L_IRQ_VEC : L_RST_VEC;
        end
    end
`else
    localparam int unsigned lp_unused_irq_vec = IRQ_VEC_ADDR;
    logic w_unused_irq;

    assign w_unused_irq = ^{irq_req, ret_en};
    assign vec_addr     = L_RST_VEC;
    assign in_isr       = 1'b0;
    assign irq_ack      = 1'b0;

    // Next-state and datapath decode without interrupt support.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        case (r_state)
            ST_BOOT_RD: begin
                w_state_nxt = ST_BOOT_LD;
            end
            ST_BOOT_LD: begin
                w_pc_nxt    = vec_data;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_en) begin
                    w_pc_nxt = redirect_pc;
                end else if (StallF) begin
                    w_pc_nxt = r_pc;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT_RD;
                w_pc_nxt    = {ADDR_W{1'b0}};
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT_RD;
            r_pc    <= {ADDR_W{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; interrupt scenarios follow PC_IRQ_EN the same way the design does.
module tb_pc_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       StallF;
    logic       redirect_en;
    logic [7:0] redirect_pc;
    logic       irq_req;
    logic       ret_en;
    logic [7:0] vec_addr;
    logic [7:0] vec_data;
    logic [7:0] pc_out;
    logic       pc_valid;
    logic       in_isr;
    logic       irq_ack;

    logic [7:0]  mem [0:255];
    logic [18:0] obs;
    logic [18:0] exp_v;
    int          n_cmp = 0;
    int          n_err = 0;

    pc_fetch_ctrl dut (
        .clk(clk), .reset_n(reset_n), .StallF(StallF), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .irq_req(irq_req), .ret_en(ret_en),
        .vec_addr(vec_addr), .vec_data(vec_data), .pc_out(pc_out),
        .pc_valid(pc_valid), .in_isr(in_isr), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous-read vector memory.
    always @(posedge clk) vec_data <= mem[vec_addr];

    // obs = {pc_valid, in_isr, irq_ack, vec_addr, pc_out}
    assign obs = {pc_valid, in_isr, irq_ack, vec_addr, pc_out};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; StallF = 1'b0; redirect_en = 1'b0; redirect_pc = 8'h00;
        irq_req = 1'b0; ret_en = 1'b0;
        step(); step();
        exp_v = {1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_boot();
        reset_n = 1'b1;
        step();
        exp_v = {1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL boot_ld: got %h want %h", obs, exp_v); end
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 8'h40 + 8'(i)};
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL boot_seq%0d: got %h want %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_stall_wrap();
        redirect_en = 1'b1; redirect_pc = 8'hFE;
        step();
        redirect_en = 1'b0; StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 8'hFE};
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL stall%0d: got %h want %h", i, obs, exp_v); end
        end
        StallF = 1'b0;
        step();
        exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 8'hFF};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_ff: got %h want %h", obs, exp_v); end
        step();
        exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_00: got %h want %h", obs, exp_v); end
    endtask

`ifdef PC_IRQ_EN
    task automatic test_redirect_irq();
        redirect_en = 1'b1; redirect_pc = 8'h10;
        step();
        redirect_pc = 8'h80; irq_req = 1'b1;
        step();
        exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 8'h80};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL redir_wins: got %h want %h", obs, exp_v); end
        redirect_en = 1'b0;
        step();
        exp_v = {1'b0, 1'b0, 1'b0, 8'h01, 8'h80};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL irq_rd: got %h want %h", obs, exp_v); end
        irq_req = 1'b0;
        step();
        exp_v = {1'b0, 1'b0, 1'b1, 8'h01, 8'h80};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL irq_ld: got %h want %h", obs, exp_v); end
        step();
        exp_v = {1'b1, 1'b1, 1'b0, 8'h00, 8'hC0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL isr_entry: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_return();
        irq_req = 1'b1;
        step();
        exp_v = {1'b1, 1'b1, 1'b0, 8'h00, 8'hC1};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL irq_masked: got %h want %h", obs, exp_v); end
        irq_req = 1'b0;
        step(); step();
        ret_en = 1'b1;
        step();
        exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 8'h81};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ret_epc: got %h want %h", obs, exp_v); end
        step();
        exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 8'h82};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ret_ignored: got %h want %h", obs, exp_v); end
        ret_en = 1'b0;
    endtask

    task automatic test_redirect_entry();
        irq_req = 1'b1;
        step();
        irq_req = 1'b0; redirect_en = 1'b1; redirect_pc = 8'h20;
        step();
        redirect_en = 1'b0;
        step();
        exp_v = {1'b1, 1'b1, 1'b0, 8'h00, 8'hC0};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL entry_redir_isr: got %h want %h", obs, exp_v); end
        ret_en = 1'b1;
        step();
        ret_en = 1'b0;
        exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 8'h20};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL entry_redir_ret: got %h want %h", obs, exp_v); end
    endtask
`else
    task automatic test_irq_disabled();
        redirect_en = 1'b1; redirect_pc = 8'h10;
        step();
        redirect_en = 1'b0; irq_req = 1'b1; ret_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 8'h11 + 8'(i)};
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL irq_off%0d: got %h want %h", i, obs, exp_v); end
        end
        irq_req = 1'b0; ret_en = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
`ifdef PC_IRQ_EN
        irq_req = 1'b1;
        step(); step();
        irq_req = 1'b0;
        exp_v = {1'b0, 1'b0, 1'b1, 8'h01, 8'h20};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL pre_abort_ld: got %h want %h", obs, exp_v); end
`else
        irq_req = 1'b1;
        step();
`endif
        #2 reset_n = 1'b0;
        #1;
        exp_v = {1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL async_abort: got %h want %h", obs, exp_v); end
        irq_req = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        n_cmp++;
        if (pc_valid !== 1'b0) begin n_err++; $display("FAIL reboot_ld: got %b want 0", pc_valid); end
        step();
        exp_v = {1'b1, 1'b0, 1'b0, 8'h00, 8'h40};
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reboot_pc: got %h want %h", obs, exp_v); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h40;
        mem[1] = 8'hC0;
        test_reset();
        test_boot();
        test_stall_wrap();
`ifdef PC_IRQ_EN
        test_redirect_irq();
        test_return();
        test_redirect_entry();
`else
        test_irq_disabled();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
